// File: rtl/router_pkg.sv
// Shared types for the route lookup ingress stage:
// result reason codes, FSM states and header constants.
package router_pkg;

  localparam int unsigned IPV4_W     = 32;
  localparam int unsigned KEY_W      = 68;
  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    REASON_OK       = 2'b00,
    REASON_NOT_IPV4 = 2'b01,
    REASON_SHORT    = 2'b10,
    REASON_NO_ROUTE = 2'b11
  } reason_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOOKUP,
    ST_RESULT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/route_lookup_ctrl.sv
// Parses an Ethernet/IPv4 byte stream, drives the TCAM key with the
// destination address and returns one next-hop result per frame.
module route_lookup_ctrl
  import router_pkg::*;
#(
  parameter int unsigned ETYPE_OFS  = 12,
  parameter int unsigned DIP_OFS    = 30,
  parameter int unsigned LOOKUP_LAT = 2,
  parameter logic [3:0]  NOROUTE_IF = 4'hF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  output logic              rx_ready,
  output logic [KEY_W-1:0]  tcam_key,
  input  logic [31:0]       tcam_next_hop,
  input  logic [3:0]        tcam_if_idx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_dst_ip,
  output logic [31:0]       res_next_hop,
  output logic [3:0]        res_if_idx,
  output logic [1:0]        res_reason,
  output logic [CNT_W-1:0]  stat_ok,
  output logic [CNT_W-1:0]  stat_drop
);

  localparam int unsigned BC_W  = $clog2(DIP_OFS + 5);
  localparam int unsigned LAT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

  state_e              state_q, state_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [7:0]          etype_hi_q, etype_hi_d;
  logic [IPV4_W-1:0]   dst_q, dst_d;
  logic [IPV4_W-1:0]   key_q, key_d;
  logic                eof_seen_q, eof_seen_d;
  logic [31:0]         res_dst_q, res_dst_d;
  logic [31:0]         res_hop_q, res_hop_d;
  logic [3:0]          res_if_q, res_if_d;
  reason_e             res_rsn_q, res_rsn_d;
  logic [CNT_W-1:0]    stat_ok_q, stat_ok_d;
  logic [CNT_W-1:0]    stat_drop_q, stat_drop_d;

  logic                acc;
  logic                drop;
  reason_e             drop_rsn;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    etype_hi_d  = etype_hi_q;
    dst_d       = dst_q;
    key_d       = key_q;
    eof_seen_d  = eof_seen_q;
    res_dst_d   = res_dst_q;
    res_hop_d   = res_hop_q;
    res_if_d    = res_if_q;
    res_rsn_d   = res_rsn_q;
    stat_ok_d   = stat_ok_q;
    stat_drop_d = stat_drop_q;
    rx_ready    = (state_q == ST_IDLE) ||
                  (state_q == ST_HDR) ||
                  (state_q == ST_DRAIN);
    res_valid   = (state_q == ST_RESULT);
    acc         = rx_valid && rx_ready;
    drop        = 1'b0;
    drop_rsn    = REASON_OK;

    unique case (state_q)
      ST_HDR: begin
        if (acc && !rx_sof) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BC_W'(ETYPE_OFS))
            etype_hi_d = rx_data;
          if (byte_cnt_q >= BC_W'(DIP_OFS))
            dst_d = {dst_q[23:0], rx_data};
          if (byte_cnt_q == BC_W'(ETYPE_OFS + 1) &&
              {etype_hi_q, rx_data} != ETYPE_IPV4) begin
            drop     = 1'b1;
            drop_rsn = REASON_NOT_IPV4;
          end else if (byte_cnt_q == BC_W'(DIP_OFS + 3)) begin
            key_d      = {dst_q[23:0], rx_data};
            lat_cnt_d  = '0;
            eof_seen_d = rx_eof;
            state_d    = ST_LOOKUP;
          end else if (rx_eof) begin
            drop     = 1'b1;
            drop_rsn = REASON_SHORT;
          end
        end
      end
      ST_LOOKUP: begin
        if (lat_cnt_q == LAT_W'(LOOKUP_LAT - 1)) begin
          res_dst_d = key_q;
          res_hop_d = tcam_next_hop;
          res_if_d  = tcam_if_idx;
          res_rsn_d = (tcam_if_idx == NOROUTE_IF) ?
                      REASON_NO_ROUTE : REASON_OK;
          state_d   = ST_RESULT;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          if (res_rsn_q == REASON_OK)
            stat_ok_d = stat_ok_q + 1'b1;
          else
            stat_drop_d = stat_drop_q + 1'b1;
          state_d = eof_seen_q ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (acc && rx_eof)
          state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A start-of-frame byte always restarts the parse, even mid-header
    if (acc && rx_sof) begin
      byte_cnt_d = BC_W'(1);
      eof_seen_d = 1'b0;
      dst_d      = '0;
      state_d    = ST_HDR;
      drop       = rx_eof;
      drop_rsn   = REASON_SHORT;
    end

    if (drop) begin
      res_rsn_d  = drop_rsn;
      res_dst_d  = '0;
      res_hop_d  = '0;
      res_if_d   = '0;
      eof_seen_d = rx_eof;
      state_d    = ST_RESULT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      etype_hi_q  <= '0;
      dst_q       <= '0;
      key_q       <= '0;
      eof_seen_q  <= 1'b0;
      res_dst_q   <= '0;
      res_hop_q   <= '0;
      res_if_q    <= '0;
      res_rsn_q   <= REASON_OK;
      stat_ok_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      etype_hi_q  <= etype_hi_d;
      dst_q       <= dst_d;
      key_q       <= key_d;
      eof_seen_q  <= eof_seen_d;
      res_dst_q   <= res_dst_d;
      res_hop_q   <= res_hop_d;
      res_if_q    <= res_if_d;
      res_rsn_q   <= res_rsn_d;
      stat_ok_q   <= stat_ok_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign tcam_key     = {{(KEY_W - IPV4_W){1'b0}}, key_q};
  assign res_dst_ip   = res_dst_q;
  assign res_next_hop = res_hop_q;
  assign res_if_idx   = res_if_q;
  assign res_reason   = res_rsn_q;
  assign stat_ok      = stat_ok_q;
  assign stat_drop    = stat_drop_q;

endmodule

// File: tb/tb_route_lookup_ctrl.sv
// Frame-level reference model bench for route_lookup_ctrl with
// directed scenarios followed by randomized frames.
module tb_route_lookup_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_sof = 1'b0;
  logic        rx_eof = 1'b0;
  logic        rx_ready;
  logic [67:0] tcam_key;
  logic [31:0] tcam_next_hop = '0;
  logic [3:0]  tcam_if_idx = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_dst_ip;
  logic [31:0] res_next_hop;
  logic [3:0]  res_if_idx;
  logic [1:0]  res_reason;
  logic [15:0] stat_ok;
  logic [15:0] stat_drop;

  route_lookup_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_ready(rx_ready),
    .tcam_key(tcam_key), .tcam_next_hop(tcam_next_hop),
    .tcam_if_idx(tcam_if_idx),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_dst_ip(res_dst_ip), .res_next_hop(res_next_hop),
    .res_if_idx(res_if_idx), .res_reason(res_reason),
    .stat_ok(stat_ok), .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hop_of(input logic [31:0] ip);
    return {ip[31:8], 8'hFE};
  endfunction

  function automatic logic [3:0] if_of(input logic [31:0] ip);
    return ip[3:0];
  endfunction

  // TCAM stand-in: outputs follow the key one register later
  always @(posedge clk) begin
    tcam_next_hop <= hop_of(tcam_key[31:0]);
    tcam_if_idx   <= if_of(tcam_key[31:0]);
  end

  typedef struct {
    logic [1:0]  reason;
    logic [31:0] dst;
    logic [31:0] hop;
    logic [3:0]  ifx;
    int          vcyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mkey = '0;
  logic [15:0] m_ok = '0;
  logic [15:0] m_drop = '0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  bit          rr_hold = 1'b0;
  logic [7:0]  fr [0:127];
  int          last_term;
  logic [31:0] last_dst, last_hop;
  logic [3:0]  last_if;
  logic [1:0]  last_rsn;

  task automatic chk(input string nm, input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_ready", rx_ready, q.size() == 0);
      chk("res_valid", res_valid,
          q.size() > 0 && cyc >= q[0].vcyc);
      chk("tcam_key", tcam_key, {36'd0, mkey});
      chk("stat_ok", stat_ok, m_ok);
      chk("stat_drop", stat_drop, m_drop);
      if (res_valid && q.size() > 0) begin
        chk("res_reason", res_reason, q[0].reason);
        chk("res_dst_ip", res_dst_ip, q[0].dst);
        chk("res_next_hop", res_next_hop, q[0].hop);
        chk("res_if_idx", res_if_idx, q[0].ifx);
        if (res_ready) begin
          last_dst = res_dst_ip;
          last_hop = res_next_hop;
          last_if  = res_if_idx;
          last_rsn = res_reason;
          if (q[0].reason == 2'd0) m_ok++;
          else m_drop++;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_hold ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic make_frame(input logic [31:0] ip,
                            input logic [15:0] et);
    for (int i = 0; i < 128; i++) fr[i] = 8'($urandom);
    fr[12] = et[15:8];
    fr[13] = et[7:0];
    fr[30] = ip[31:24];
    fr[31] = ip[23:16];
    fr[32] = ip[15:8];
    fr[33] = ip[7:0];
  endtask

  task automatic send_frame(input int len, input bit has_eof,
                            input bit stop_at_term);
    int          term;
    logic [1:0]  rsn;
    logic [31:0] dip;
    bit          rd;
    bit          acc;
    exp_t        e;
    term = -1;
    rsn  = 2'd0;
    dip  = '0;
    for (int i = 0; i < len && term < 0; i++) begin
      if (i == 13 && {fr[12], fr[13]} != 16'h0800) begin
        term = i;
        rsn  = 2'd1;
      end else if (i == 33) begin
        term = i;
        dip  = {fr[30], fr[31], fr[32], fr[33]};
        rsn  = (if_of(dip) == 4'hF) ? 2'd3 : 2'd0;
      end else if (has_eof && i == len - 1) begin
        term = i;
        rsn  = 2'd2;
      end
    end
    last_term = term;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        rx_sof   = 1'($urandom);
        rx_eof   = 1'($urandom);
        @(posedge clk);
        #1;
      end
      rx_valid = 1'b1;
      rx_data  = fr[i];
      rx_sof   = (i == 0);
      rx_eof   = has_eof && (i == len - 1);
      acc = 1'b0;
      for (int w = 0; w < 200 && !acc; w++) begin
        rd = rx_ready;
        @(posedge clk);
        #1;
        acc = rd;
      end
      if (!acc) begin
        chk("rx_accept_timeout", 1'b0, 1'b1);
        rx_valid = 1'b0;
        return;
      end
      if (i == term) begin
        e.reason = rsn;
        e.dst    = (term == 33) ? dip : 32'd0;
        e.hop    = (term == 33) ? hop_of(dip) : 32'd0;
        e.ifx    = (term == 33) ? if_of(dip) : 4'd0;
        e.vcyc   = (term == 33) ? cyc + LAT : cyc;
        if (term == 33) mkey = dip;
        q.push_back(e);
        if (stop_at_term) begin
          rx_valid = 1'b0;
          return;
        end
      end
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_eof   = 1'b0;
  endtask

  task automatic send_junk(input int n);
    bit rd;
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
      rd = rx_ready;
      @(posedge clk);
      #1;
      if (!rd) i--;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int w;
    for (w = 0; w < 400 && q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) chk("result_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int   len;
    bit   heof;
    bit   open;
    logic [31:0] ip;
    logic [15:0] et;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len;
    bit          heof;
    bit          open;
    logic [31:0] ip;
    logic [15:0] et;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_tcam_key", tcam_key, 68'd0);
    chk("rst_stat_ok", stat_ok, 16'd0);
    chk("rst_stat_drop", stat_drop, 16'd0);
    chk("rst_res_hop", res_next_hop, 32'd0);
    chk_en = 1'b1;

    // 1: routed frame with tail drained
    make_frame(32'h0A010203, 16'h0800);
    send_frame(60, 1'b1, 1'b0);
    wait_empty();
    chk("t1_key", tcam_key[31:0], 32'h0A010203);
    chk("t1_hop", last_hop, 32'h0A0102FE);
    chk("t1_if", last_if, 4'd3);
    chk("t1_reason", last_rsn, 2'd0);
    chk("t1_stat_ok", stat_ok, 16'd1);

    // 2: IPv6 EtherType
    make_frame(32'hDEADBEEF, 16'h86DD);
    send_frame(50, 1'b1, 1'b0);
    wait_empty();
    chk("t2_reason", last_rsn, 2'd1);
    chk("t2_key", tcam_key[31:0], 32'h0A010203);
    chk("t2_stat_drop", stat_drop, 16'd1);

    // 3: short frame
    make_frame(32'h01010101, 16'h0800);
    send_frame(20, 1'b1, 1'b0);
    wait_empty();
    chk("t3_reason", last_rsn, 2'd2);
    chk("t3_stat_drop", stat_drop, 16'd2);

    // 4: no route, result held by back-pressure
    rr_hold = 1'b1;
    make_frame(32'hC0A8010F, 16'h0800);
    send_frame(34, 1'b1, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("t4_held_valid", res_valid, 1'b1);
    chk("t4_held_rx_ready", rx_ready, 1'b0);
    chk("t4_held_drop", stat_drop, 16'd2);
    rr_hold = 1'b0;
    wait_empty();
    chk("t4_reason", last_rsn, 2'd3);
    chk("t4_if", last_if, 4'hF);
    chk("t4_stat_drop", stat_drop, 16'd3);

    // 5: reset during lookup, then a clean frame
    make_frame(32'h0A000001, 16'h0800);
    send_frame(40, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_ok = '0;
    m_drop = '0;
    mkey = '0;
    chk_en = 1'b1;
    make_frame(32'h0A0B0C0D, 16'h0800);
    send_frame(36, 1'b1, 1'b0);
    wait_empty();
    chk("t5_dst", last_dst, 32'h0A0B0C0D);
    chk("t5_hop", last_hop, 32'h0A0B0CFE);
    chk("t5_stat_ok", stat_ok, 16'd1);
    chk("t5_stat_drop", stat_drop, 16'd0);

    // 6: new sof at byte 20 aborts the first frame
    make_frame(32'h01020304, 16'h0800);
    send_frame(20, 1'b0, 1'b0);
    make_frame(32'h0A141E28, 16'h0800);
    send_frame(40, 1'b1, 1'b0);
    wait_empty();
    chk("t6_dst", last_dst, 32'h0A141E28);
    chk("t6_stat_ok", stat_ok, 16'd2);
    chk("t6_stat_drop", stat_drop, 16'd0);

    open = 1'b0;
    for (int n = 0; n < 150; n++) begin
      ip = $urandom;
      if ($urandom_range(0, 3) == 0) ip[3:0] = 4'hF;
      et = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h0800;
      len  = $urandom_range(1, 60);
      heof = ($urandom_range(0, 7) != 0);
      if (!open && $urandom_range(0, 3) == 0)
        send_junk($urandom_range(1, 3));
      make_frame(ip, et);
      send_frame(len, heof, 1'b0);
      open = !heof && last_term < 0;
    end
    wait_empty();
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
